// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter.
//   arb_state_t : arbitration FSM state
//   req_id_t    : requester index (REQ_CORE = core fetch/load-store, REQ_DMA = DMA/test loader)
//   rd_tag_t    : in-flight read tag {valid, id} carried alongside the memory read latency
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_CORE = 1'b0;
    localparam req_id_t REQ_DMA  = 1'b1;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    function automatic arb_state_t lock_state(input req_id_t id);
        return (id == REQ_DMA) ? ST_LOCK1 : ST_LOCK0;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker for the memory-port arbiter.
//   req        : request vector {req1, req0}
//   lock       : lock-after-beat vector {lock1, lock0}
//   state      : current arbitration state
//   last_owner : requester granted most recently (round-robin pointer)
//   starve     : lock holder has used up its consecutive-grant allowance
//   gnt        : one-hot (or zero) grant vector
//   next_state : arbitration state for the next cycle
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_FREE  | round-robin between requesters, tie goes to != last_owner
// ST_LOCK0 | requester 0 holds the port; requester 1 waits
// ST_LOCK1 | requester 1 holds the port; requester 0 waits
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  arb_state_t state,
    input  req_id_t    last_owner,
    input  logic       starve,
    output logic [1:0] gnt,
    output arb_state_t next_state
);

    req_id_t free_id;
    req_id_t owner;

    always_comb begin
        gnt        = 2'b00;
        next_state = ST_FREE;
        free_id    = (req == 2'b11) ? ~last_owner : req[1];
        owner      = (state == ST_LOCK1) ? REQ_DMA : REQ_CORE;

        if ((state != ST_FREE) && req[owner]) begin
            if (starve && req[~owner]) begin
                // Forced handover: the waiting side takes this beat and
                // the lock is dropped.
                gnt[~owner] = 1'b1;
            end else begin
                gnt[owner] = 1'b1;
                next_state = lock[owner] ? state : ST_FREE;
            end
        end else if (|req) begin
            // Also reached from a lock state whose owner dropped its
            // request: the lock is released in the same cycle and the
            // other requester is arbitrated as if the port were free.
            gnt[free_id] = 1'b1;
            if (lock[free_id]) begin
                next_state = lock_state(free_id);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the processor's single memory port.
// Requester 0 is the core, requester 1 the DMA/test loader. Round-robin
// with optional burst lock and a starvation limit on locked bursts.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_reqN/i_weN/i_lockN         request, write (1) / read (0), keep port after beat
//   i_addrN/i_wdataN             request address and write data
//   o_gntN                       beat accepted this cycle (combinational)
//   o_rvalidN/o_rdataN           read return, two cycles after the grant
//   o_memAddr/o_memData/o_memWrEnable  registered memory-side command
//   i_memData                    memory read data, one cycle after address
//   o_grantCnt0/1, o_conflictCnt statistics counters
//
// Build option: define MEM_ARB_STATS_EN to build the saturating grant and
// conflict counters; otherwise those outputs are tied to zero.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 8
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memData,
    output logic              o_memWrEnable,
    input  logic [DATA_W-1:0] i_memData,
    output logic [15:0]       o_grantCnt0,
    output logic [15:0]       o_grantCnt1,
    output logic [15:0]       o_conflictCnt
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_t        state_q;
    arb_state_t        state_d;
    req_id_t           last_owner_q;
    logic [7:0]        starve_cnt_q;
    logic [7:0]        starve_cnt_d;
    logic [1:0]        req_vec;
    logic [1:0]        lock_vec;
    logic [1:0]        gnt_vec;
    logic              starve;
    logic              granted;
    req_id_t           gnt_id;
    logic              other_waiting;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    rd_tag_t           tag_s1_q;
    rd_tag_t           tag_s2_q;

    assign req_vec  = {i_req1, i_req0};
    assign lock_vec = {i_lock1, i_lock0};
    assign starve   = (starve_cnt_q >= LIMIT);

    mem_arb_pick u_pick (
        .req        (req_vec),
        .lock       (lock_vec),
        .state      (state_q),
        .last_owner (last_owner_q),
        .starve     (starve),
        .gnt        (gnt_vec),
        .next_state (state_d)
    );

    assign granted       = |gnt_vec;
    assign gnt_id        = gnt_vec[1];
    assign other_waiting = (gnt_id == REQ_DMA) ? i_req0 : i_req1;

    assign sel_we    = (gnt_id == REQ_DMA) ? i_we1    : i_we0;
    assign sel_addr  = (gnt_id == REQ_DMA) ? i_addr1  : i_addr0;
    assign sel_wdata = (gnt_id == REQ_DMA) ? i_wdata1 : i_wdata0;

    // The counter tracks how many beats the current lock owner has taken
    // while the other side waited, including the beat that took the lock.
    // Any change of state (release, handover, new owner) restarts it.
    always_comb begin
        starve_cnt_d = (state_d == state_q) ? starve_cnt_q : 8'd0;
        if (state_d == ST_FREE) begin
            starve_cnt_d = 8'd0;
        end else if (granted && other_waiting) begin
            starve_cnt_d = starve_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_FREE;
            last_owner_q  <= REQ_DMA;
            starve_cnt_q  <= 8'd0;
            o_memAddr     <= '0;
            o_memData     <= '0;
            o_memWrEnable <= 1'b0;
            tag_s1_q      <= '0;
            tag_s2_q      <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            o_memWrEnable <= granted & sel_we;
            tag_s1_q      <= '{valid: granted & ~sel_we, id: gnt_id};
            tag_s2_q      <= tag_s1_q;
            if (granted) begin
                last_owner_q <= gnt_id;
                o_memAddr    <= sel_addr;
                o_memData    <= sel_wdata;
            end
        end
    end

    // Grants are combinational, so they are masked while reset is held to
    // keep every output low during reset.
    assign o_gnt0 = gnt_vec[0] & ~i_rst;
    assign o_gnt1 = gnt_vec[1] & ~i_rst;

    assign o_rvalid0 = tag_s2_q.valid && (tag_s2_q.id == REQ_CORE);
    assign o_rvalid1 = tag_s2_q.valid && (tag_s2_q.id == REQ_DMA);
    assign o_rdata0  = o_rvalid0 ? i_memData : '0;
    assign o_rdata1  = o_rvalid1 ? i_memData : '0;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] grant_cnt0_q;
    logic [15:0] grant_cnt1_q;
    logic [15:0] conflict_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_cnt0_q   <= 16'd0;
            grant_cnt1_q   <= 16'd0;
            conflict_cnt_q <= 16'd0;
        end else begin
            if (gnt_vec[0] && (grant_cnt0_q != 16'hFFFF)) begin
                grant_cnt0_q <= grant_cnt0_q + 16'd1;
            end
            if (gnt_vec[1] && (grant_cnt1_q != 16'hFFFF)) begin
                grant_cnt1_q <= grant_cnt1_q + 16'd1;
            end
            if (i_req0 && i_req1 && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    assign o_grantCnt0   = grant_cnt0_q;
    assign o_grantCnt1   = grant_cnt1_q;
    assign o_conflictCnt = conflict_cnt_q;
`else
    assign o_grantCnt0   = 16'd0;
    assign o_grantCnt1   = 16'd0;
    assign o_conflictCnt = 16'd0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single 16-bit memory port between two requesters: requester 0 (core fetch/load-store) and requester 1 (DMA/test loader).
- Round-robin arbitration with optional burst lock and a starvation limit.
- Drives the memory-side address, write data and write enable.
- Routes read data back to the requester that issued the read.

Parameters:
- DATA_W, 16, memory data width
- ADDR_W, 16, memory address width
- STARVE_LIMIT, 8, max consecutive locked grants to one requester while the other is waiting (range 1..255)

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous reset, active-high
- i_req0 / i_req1  input  1  request valid
- i_we0 / i_we1  input  1  1 = write, 0 = read
- i_lock0 / i_lock1  input  1  hold ownership after this beat
- i_addr0 / i_addr1  input  ADDR_W  request address
- i_wdata0 / i_wdata1  input  DATA_W  write data
- o_gnt0 / o_gnt1  output  1  request accepted this cycle (combinational)
- o_rvalid0 / o_rvalid1  output  1  read data valid
- o_rdata0 / o_rdata1  output  DATA_W  read data (equals i_memData)
- o_memAddr  output  ADDR_W  memory address (registered)
- o_memData  output  DATA_W  memory write data (registered)
- o_memWrEnable  output  1  memory write strobe (registered)
- i_memData  input  DATA_W  memory read data, valid one cycle after address
- o_grantCnt0 / o_grantCnt1  output  16  grant counters (optional feature)
- o_conflictCnt  output  16  conflict counter (optional feature)

Behaviour:
- Reset (async, i_rst=1): state ST_FREE, last_owner=1, starve_cnt=0, all outputs 0, in-flight read tags cleared. A read accepted before reset never produces rvalid.
- At most one grant per cycle. A request is accepted in cycle T iff o_gntN=1 in T.
- Accepted beat at T:
  - o_memAddr, o_memData and o_memWrEnable (= i_weN) are registered and appear in T+1.
  - o_memWrEnable is a one-cycle pulse.
  - Reads: o_rvalidN=1 in T+2 with o_rdataN=i_memData; the other requester's rvalid stays 0.
- Idle cycle (no grant): o_memWrEnable=0; o_memAddr and o_memData hold their previous values.
- Back-to-back grants sustain one beat per cycle. Reads and writes may interleave freely; the tag pipeline is 2 deep.
- States:
  - ST_FREE: single requester -> granted. Both requesting -> grant the requester != last_owner. On the granted beat, i_lockN=1 -> ST_LOCKN.
  - ST_LOCKN: requester N has exclusive priority; the other is not granted.
    - Granted beat with i_lockN=0 -> ST_FREE.
    - i_reqN=0 in any cycle -> ST_FREE in the same cycle; the other requester may be granted that cycle.
- starve_cnt:
  - Increments on each ST_LOCKN grant while the other requester is asserting.
  - When starve_cnt==STARVE_LIMIT and the other requester is asserting: forced handover. The other requester is granted that cycle, state -> ST_FREE, starve_cnt=0, and the lock-holder's beat is not granted.
  - Clears on any transition to ST_FREE.
- last_owner updates on every grant.
- Write data and address are sampled only on the grant cycle. Requesters hold request fields stable until granted.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - o_grantCnt0/1 count accepted beats per requester, saturating at 16'hFFFF.
  - o_conflictCnt counts cycles with i_req0 && i_req1, saturating.
  - All counters reset to 0.
- Undefined: the three ports are tied to 0 and no counter flops are built.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ST_FREE, ST_LOCK0, ST_LOCK1}
  - req_id_t (1 bit)
  - REQ_CORE=0, REQ_DMA=1
  - read-tag struct {valid, id}
- Sub-module mem_arb_pick: combinational grant picker. Inputs: requests, state, last_owner, starve flag. Outputs: grant vector and next state. Keeps the top level to registers and routing.

Test Plan:
- Single read: i_req0, i_we0=0, i_addr0=16'h0040 at T -> o_gnt0=1 at T; o_memAddr=16'h0040, o_memWrEnable=0 at T+1; memory returns 16'hBEEF -> o_rvalid0=1, o_rdata0=16'hBEEF at T+2; o_rvalid1=0.
- Tie after reset: both request at first cycle -> requester 0 granted, next cycle requester 1, alternating 0,1,0,1 over 4 cycles.
- Write pulse: i_req1, i_we1=1, addr 16'h1234, wdata 16'h00A5 -> o_memWrEnable=1 for exactly one cycle at T+1 with addr 16'h1234 and data 16'h00A5.
- Lock and starvation (STARVE_LIMIT=8): requester 1 asserts i_lock1 continuously while requester 0 waits -> 8 consecutive grants to requester 1, then o_gnt0=1 on the 9th cycle, then round-robin.
- Reset mid-read: read granted at T, i_rst pulsed at T+1 -> no o_rvalid at T+2; all outputs 0 during reset.
- Stats (MEM_ARB_STATS_EN): 10 cycles with both requesting, no lock -> o_conflictCnt=10, o_grantCnt0=5, o_grantCnt1=5.
